// File: rtl/press_event_classifier_pkg.sv
// press_pkg: shared constants for the press event classifier.
// Holds the default tick thresholds, the FSM state encodings and the
// event identifiers used when scoreboarding classifier output.
package press_pkg;

  // Default thresholds, in 10 ms ticks
  localparam int unsigned LONG_TICKS_DEF   = 50;
  localparam int unsigned DBL_TICKS_DEF    = 25;
  localparam int unsigned REPEAT_TICKS_DEF = 10;
  localparam int unsigned CNT_W_DEF        = 8;

  // Classifier states; encodings 5..7 are illegal and recover to IDLE
  localparam int unsigned ST_W   = 3;
  localparam logic [2:0]  IDLE   = 3'd0;
  localparam logic [2:0]  PRESS1 = 3'd1;
  localparam logic [2:0]  GAP    = 3'd2;
  localparam logic [2:0]  PRESS2 = 3'd3;
  localparam logic [2:0]  LONG   = 3'd4;

  // Event identifiers for scoreboarding
  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_SHORT  = 3'd1,
    EV_LONG   = 3'd2,
    EV_DOUBLE = 3'd3,
    EV_REPEAT = 3'd4
  } event_e;

endpackage

// File: rtl/press_event_classifier_timer.sv
// press_timer: saturating tick counter with a threshold compare.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   clr          - clear the count (wins over tick)
//   tick         - count enable strobe
//   limit        - threshold; hit_c fires on the tick that reaches it
//   hit_c        - combinational: tick && (count == limit-1)
module press_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             hit_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority; increment saturates at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_c = tick && (cnt_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/press_event_classifier.sv
// press_event_classifier: classifies debounced presses into short, long
// and double-click events, with a held-level flag.
// Optional feature: define PRESS_AUTOREPEAT_EN to emit repeat_p every
// REPEAT_TICKS while held long; otherwise repeat_p is tied 0.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   db         - debounced switch level (1 = pressed), synchronous to clk
//   tick10     - one-clk strobe every 10 ms
//   short_p    - pulse: single short press completed
//   long_p     - pulse: press reached LONG_TICKS
//   double_p   - pulse: double click completed
//   held       - level: state was LONG on the previous cycle
//   repeat_p   - pulse: auto-repeat while held long
module press_event_classifier
  import press_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = LONG_TICKS_DEF,
  parameter int unsigned DBL_TICKS    = DBL_TICKS_DEF,
  parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  input  logic tick10,
  output logic short_p,
  output logic long_p,
  output logic double_p,
  output logic held,
  output logic repeat_p
);

  logic [ST_W-1:0]  state_q, state_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             held_q, held_d;
  logic             clr;
  logic             hit;
  logic [CNT_W-1:0] limit;
`ifdef PRESS_AUTOREPEAT_EN
  logic             repeat_q, repeat_d;
  logic             rep_clr;
`endif

  press_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick10),
    .limit (limit),
    .hit_c (hit)
  );

  // Next state and pulses; a db change is checked before any threshold
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    limit    = CNT_W'(LONG_TICKS);
`ifdef PRESS_AUTOREPEAT_EN
    repeat_d = 1'b0;
    rep_clr  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (db) state_d = PRESS1;
      end
      PRESS1: begin
        if (!db) begin
          state_d = GAP;
        end else if (hit) begin
          state_d = LONG;
          long_d  = 1'b1;
        end
      end
      GAP: begin
        limit = CNT_W'(DBL_TICKS);
        if (db) begin
          state_d = PRESS2;
        end else if (hit) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (!db) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end else if (hit) begin
          // First click of an aborted double still counts as short
          state_d = LONG;
          short_d = 1'b1;
          long_d  = 1'b1;
        end
      end
      LONG: begin
        limit = CNT_W'(REPEAT_TICKS);
        if (!db) begin
          state_d = IDLE;
        end
`ifdef PRESS_AUTOREPEAT_EN
        else if (hit) begin
          repeat_d = 1'b1;
          rep_clr  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on every state change (and on each repeat)
`ifdef PRESS_AUTOREPEAT_EN
  assign clr = (state_d != state_q) || rep_clr;
`else
  assign clr = (state_d != state_q);
`endif

  assign held_d = (state_q == LONG);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= held_d;
    end
  end

`ifdef PRESS_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end
  assign repeat_p = repeat_q;
`else
  assign repeat_p = 1'b0;
`endif

  assign short_p  = short_q;
  assign long_p   = long_q;
  assign double_p = double_q;
  assign held     = held_q;

endmodule

// File: tb/tb_press_event_classifier.sv
// Bench for press_event_classifier: directed gestures with a pulse
// scoreboard. Expected pulses are queued with the clk edge on which the
// deciding sample is taken; a negedge monitor pops and compares them.
module tb_press_event_classifier;

  logic clk = 1'b0;
  logic reset;
  logic db;
  logic tick10;
  logic short_p, long_p, double_p, held, repeat_p;

  localparam logic [3:0] P_SHORT = 4'b1000;
  localparam logic [3:0] P_LONG  = 4'b0100;
  localparam logic [3:0] P_DBL   = 4'b0010;
  localparam logic [3:0] P_REP   = 4'b0001;

  typedef struct {
    logic [3:0]  vec;
    int unsigned edge_n;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned edge_n = 0;
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  press_event_classifier #(
    .LONG_TICKS  (5),
    .DBL_TICKS   (3),
    .REPEAT_TICKS(2),
    .CNT_W       (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .db      (db),
    .tick10  (tick10),
    .short_p (short_p),
    .long_p  (long_p),
    .double_p(double_p),
    .held    (held),
    .repeat_p(repeat_p)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clk: drive on negedge, advance through the posedge
  task automatic step(input logic d, input logic t);
    @(negedge clk);
    db     = d;
    tick10 = t;
    @(posedge clk);
    edge_n++;
  endtask

  // n tick periods of 4 clk each, tick on the last clk
  task automatic ticks(input logic d, input int n);
    repeat (n) begin
      step(d, 1'b0);
      step(d, 1'b0);
      step(d, 1'b0);
      step(d, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  // Pulse expected from the edge just taken
  task automatic expect_now(input logic [3:0] v);
    exp_q.push_back('{vec: v, edge_n: edge_n});
  endtask

  task automatic chk_all_zero(input string tag);
    #1;
    chk({tag, "_short"},  32'(short_p),  32'd0);
    chk({tag, "_long"},   32'(long_p),   32'd0);
    chk({tag, "_double"}, 32'(double_p), 32'd0);
    chk({tag, "_held"},   32'(held),     32'd0);
    chk({tag, "_repeat"}, 32'(repeat_p), 32'd0);
  endtask

  task automatic chk_held(input string tag, input logic exp);
    #1;
    chk(tag, 32'(held), 32'(exp));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    logic [3:0] pv;
    exp_t       e;
    pv = {short_p, long_p, double_p, repeat_p};
    if (pv != 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(pv), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_vec", 32'(pv), 32'(e.vec));
        chk("pulse_edge", edge_n, e.edge_n);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    db     = 1'b0;
    tick10 = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_all_zero("reset");
    reset = 1'b0;
    idle(3);

    // Short press: 2 ticks high, 3rd gap tick completes it
    ticks(1'b1, 2);
    ticks(1'b0, 3);
    expect_now(P_SHORT);
    idle(6);

    // Long press held 10 ticks, then release
    ticks(1'b1, 5);
    expect_now(P_LONG);
    chk_held("held_at_long", 1'b0);
    step(1'b1, 1'b0);
    chk_held("held_after_long", 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    ticks(1'b1, 1);
`ifdef PRESS_AUTOREPEAT_EN
    expect_now(P_REP);
`endif
    ticks(1'b1, 1);
    ticks(1'b1, 1);
`ifdef PRESS_AUTOREPEAT_EN
    expect_now(P_REP);
`endif
    ticks(1'b1, 1);
    step(1'b0, 1'b0);
    chk_held("held_at_release", 1'b1);
    step(1'b0, 1'b0);
    chk_held("held_after_release", 1'b0);
    idle(6);

    // Double click
    ticks(1'b1, 1);
    ticks(1'b0, 1);
    ticks(1'b1, 1);
    step(1'b0, 1'b0);
    expect_now(P_DBL);
    idle(16);

    // Second press held long: short and long together
    ticks(1'b1, 1);
    ticks(1'b0, 1);
    ticks(1'b1, 5);
    expect_now(P_SHORT | P_LONG);
    ticks(1'b1, 1);
    step(1'b0, 1'b0);
    idle(6);

    // Gap boundary: rise on the 3rd gap tick wins over short timeout
    ticks(1'b1, 1);
    ticks(1'b0, 2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    expect_now(P_DBL);
    idle(16);

    // Reset on the tick that would make PRESS1 long
    ticks(1'b1, 4);
    reset = 1'b1;
    step(1'b1, 1'b1);
    chk_all_zero("mid_reset");
    reset = 1'b0;
    ticks(1'b0, 6);

    idle(3);
    @(negedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
